// File: rtl/wait_state_data_memory_pkg.sv
// Shared encodings for the wait-state data memory: access sizes, controller
// states and the size-to-byte-count helper.
package wait_state_data_memory_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Reserved size reports zero bytes; it is rejected separately.
  function automatic logic [2:0] access_bytes(input logic [1:0] size);
    case (size_e'(size))
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/wait_state_data_memory_lane_align.sv
// Big-endian byte-lane steering between the 32-bit bus and four consecutive
// storage bytes, plus sign/zero extension of narrow loads.
module mem_lane_align
  import wait_state_data_memory_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rbytes,
  output logic [31:0] rdata,
  output logic [31:0] wbytes,
  output logic [3:0]  lane_en
);

  // Lane i is storage byte offset+i and sits at bits [31-8i -: 8] of
  // rbytes/wbytes, so the lowest offset is always the most significant byte.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    rdata   = '0;
    wbytes  = '0;
    lane_en = '0;
    case (size_e'(size))
      SIZE_BYTE: begin
        rdata   = {{24{sign_ext & rbytes[31]}}, rbytes[31:24]};
        wbytes  = {wdata[7:0], 24'h0};
        lane_en = 4'b0001;
      end
      SIZE_HALF: begin
        rdata   = {{16{sign_ext & rbytes[31]}}, rbytes[31:16]};
        wbytes  = {wdata[15:0], 16'h0};
        lane_en = 4'b0011;
      end
      SIZE_WORD: begin
        rdata   = rbytes;
        wbytes  = wdata;
        lane_en = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wait_state_data_memory.sv
// Byte-addressed data memory that stalls every access for WAIT_CYCLES cycles
// and presents the result for one cycle in DONE.
module wait_state_data_memory
  import wait_state_data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_BYTES = 256,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           WriteData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  output logic [31:0]           ReadData,
  output logic                  ready,
  output logic                  err
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e state, next_state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            size_q;
  logic                  sext_q;
  logic                  write_q;
  logic [31:0]           result_q;
  logic                  err_q;

  logic                  req;
  logic                  access;
  logic                  reject;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH:0]   end_off;
  logic [IDX_W-1:0]      lane_idx [4];
  logic [31:0]           rbytes;
  logic [31:0]           rdata;
  logic [31:0]           wbytes;
  logic [3:0]            lane_en;

  logic [7:0] mem [DEPTH_BYTES];

  assign req    = MemRead | MemWrite;
  assign access = (state == WAIT) && (cnt == '0);

  // The extra top bit catches both a past-the-end access and an address
  // below BASE_ADDR, whose wrapped offset is huge.
  assign offset  = addr_q - ADDR_WIDTH'(BASE_ADDR);
  assign end_off = {1'b0, offset} + (ADDR_WIDTH+1)'(access_bytes(size_q));

  always_comb begin
    reject = 1'b0;
    if (size_e'(size_q) == SIZE_RSVD)                           reject = 1'b1;
    if (size_e'(size_q) == SIZE_HALF && addr_q[0])              reject = 1'b1;
    if (size_e'(size_q) == SIZE_WORD && addr_q[1:0] != 2'b00)   reject = 1'b1;
    if (end_off > (ADDR_WIDTH+1)'(DEPTH_BYTES))                 reject = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) lane_idx[i] = offset[IDX_W-1:0] + IDX_W'(i);
  end

  assign rbytes = {mem[lane_idx[0]], mem[lane_idx[1]], mem[lane_idx[2]], mem[lane_idx[3]]};

  mem_lane_align u_lane_align (
    .size    (size_q),
    .sign_ext(sext_q),
    .wdata   (wdata_q),
    .rbytes  (rbytes),
    .rdata   (rdata),
    .wbytes  (wbytes),
    .lane_en (lane_en)
  );

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = !req;
        if (req) next_state = WAIT;
      end
      WAIT: if (cnt == '0) next_state = DONE;
      DONE: begin
        ready      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign ReadData = (state == DONE) ? result_q : 32'h0;
  assign err      = (state == DONE) && err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      sext_q   <= 1'b0;
      write_q  <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          addr_q  <= address;
          wdata_q <= WriteData;
          size_q  <= size;
          sext_q  <= sign_ext;
          write_q <= MemWrite;
          cnt     <= CNT_W'(WAIT_CYCLES - 1);
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            err_q    <= reject;
            result_q <= (reject || write_q) ? 32'h0 : rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; clearing it would cost a port per byte and
  // its contents are defined only by stores. A reset mid-WAIT forces IDLE
  // asynchronously, so access is low and no write happens.
  always_ff @(posedge clk) begin
    if (access && write_q && !reject) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[lane_idx[i]] <= wbytes[31-8*i -: 8];
      end
    end
  end

endmodule

// File: doc/wait_state_data_memory.md
WAIT_STATE_DATA_MEMORY -- requirements
Module: wait_state_data_memory

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_WIDTH, 32, byte address width.
- DEPTH_BYTES, 256, storage size in bytes; power of two, at least 4.
- BASE_ADDR, 1024, byte address of storage location 0; multiple of 4.
- WAIT_CYCLES, 4, wait-state count; at least 1.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock; everything is sampled on its rising edge.
- rst, in, 1, asynchronous, active-low reset.
- address, in, ADDR_WIDTH, byte address of the access.
- WriteData, in, 32, store data, right-justified for byte and half accesses.
- MemRead, in, 1, load request.
- MemWrite, in, 1, store request.
- size, in, 2, access size: 00 byte, 01 half, 10 word; 11 is reserved.
- sign_ext, in, 1, sign-extend byte and half loads.
- ReadData, out, 32, load result.
- ready, out, 1, high when the requester may advance.
- err, out, 1, the access was rejected.

Function
REQ-003 The controller SHALL have exactly three states: IDLE, WAIT and DONE.
- A request is MemRead or MemWrite high.
REQ-004 In IDLE with a request present:
- ready SHALL go low in the same cycle, combinationally.
- The block SHALL capture address, WriteData, size, sign_ext and the access type.
- It SHALL load the wait counter with WAIT_CYCLES-1 and move to WAIT.
REQ-005 In IDLE with no request, ready SHALL be 1 and ReadData and err SHALL be 0.
REQ-006 In WAIT, ready SHALL be 0.
- While the counter is nonzero, the counter SHALL decrement.
- When the counter is 0, the block SHALL perform the access and move to DONE.
REQ-007 In DONE, ready SHALL be 1 and ReadData and err SHALL hold the result for exactly one cycle; the next state SHALL be IDLE.
REQ-008 Latency: a request accepted at edge 0 SHALL reach DONE in cycle WAIT_CYCLES+1.
- A request still asserted in IDLE after DONE SHALL be treated as a new access.
REQ-009 Input changes during WAIT and DONE SHALL be ignored; only captured values are used.
REQ-010 The byte offset SHALL be the captured address minus BASE_ADDR, computed modulo 2^ADDR_WIDTH.
REQ-011 Byte order SHALL be big-endian.
- The lowest offset holds bits [31:24] of a word or bits [15:8] of a half.
REQ-012 A store SHALL write only the bytes that size selects, in the cycle that leaves WAIT.
REQ-013 A load SHALL right-justify the selected bytes in ReadData.
- The upper bits SHALL be the loaded value's MSB if sign_ext=1, otherwise 0.
REQ-014 The access SHALL be rejected when any of these holds:
- offset+access_bytes exceeds DEPTH_BYTES, including when the subtraction wraps;
- a half access has address[0]=1;
- a word access has address[1:0] other than 00;
- size is 11.
REQ-015 A rejected access SHALL still run the full wait sequence. In DONE it SHALL:
- write nothing;
- drive ReadData=0;
- drive err=1.
REQ-016 When MemRead and MemWrite are both high, the access SHALL be a store; ReadData SHALL be 0 in DONE.

Reset
REQ-017 While rst=0, the block SHALL asynchronously force:
- state=IDLE;
- counter=0;
- all captured registers=0;
- ReadData=0, err=0, ready=1.
REQ-018 Reset during WAIT SHALL abort the access with no write performed.
- Storage contents SHALL NOT be reset, and the block SHALL NOT initialise them.
REQ-019 After rst rises, the first rising clock edge SHALL be able to accept a request.

Structure
REQ-020 The size encodings and state encodings SHALL be defined in the shared defines file.
- Parameters SHALL remain module parameters.
REQ-021 Byte-lane selection, big-endian packing and sign extension SHALL be in one combinational sub-module, mem_lane_align.
- The FSM, counter and storage SHALL be in wait_state_data_memory.
REQ-022 Storage SHALL be an array of DEPTH_BYTES 8-bit entries with a single write port.

Verification (all parameters at defaults)
REQ-023 Word store of 0xDEADBEEF to 1024, then word load from 1024:
- ready is low for 5 cycles per access.
- The load returns 0xDEADBEEF with err=0.
- Bytes 1024 to 1027 hold DE, AD, BE, EF.
REQ-024 After REQ-023, byte store of 0x80 to 1025:
- a signed byte load from 1025 returns 0xFFFFFF80;
- an unsigned byte load from 1025 returns 0x00000080;
- an unsigned half load from 1024 returns 0x0000DE80.
REQ-025 Each of the following SHALL give err=1 and ReadData=0 in DONE, with storage unchanged:
- word load from 1022;
- word load from 1278;
- half load from 1025;
- word load from 0.
REQ-026 Word store of 0x11223344 to 1028 with address and WriteData changed to 1032 and 0 mid-WAIT:
- 1028 holds 0x11223344 afterwards;
- 1032 is unchanged.
REQ-027 rst pulsed low during the third WAIT cycle of a store of 0xCAFEF00D to 1036:
- ready=1 immediately;
- state returns to IDLE;
- a later word load from 1036 returns the prior contents.
REQ-028 MemRead and MemWrite both high with 0x55 at byte 1040:
- byte 1040 is written with 0x55;
- ReadData=0 in DONE;
- back-to-back requests see ready high for exactly one cycle between accesses.
